// File: rtl/branch_resolve_unit_if.sv
// Fetch/EX-side bundle for branch_resolve_unit: prediction push, resolution,
// predictor training, redirect and status signals.
interface branch_resolve_unit_if #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 4
);
   logic                       PRED_VALID;
   logic                       PRED_READY;
   logic                       PRED_TAKEN;
   logic [PC_W-1:0]            PRED_PC;
   logic [PC_W-1:0]            PRED_TARGET;
   logic                       RES_VALID;
   logic                       RES_TAKEN;
   logic [PC_W-1:0]            RES_TARGET;
   logic                       UPD_ENABLE;
   logic                       UPD_OUTCOME;
   logic [IDX_W-1:0]           UPD_INDEX;
   logic                       MISPREDICT;
   logic [PC_W-1:0]            REDIRECT_PC;
   logic                       UNDERFLOW;
   logic [$clog2(DEPTH+1)-1:0] COUNT;

   modport master (
      output PRED_VALID, PRED_TAKEN, PRED_PC, PRED_TARGET,
      output RES_VALID, RES_TAKEN, RES_TARGET,
      input  PRED_READY, UPD_ENABLE, UPD_OUTCOME, UPD_INDEX,
      input  MISPREDICT, REDIRECT_PC, UNDERFLOW, COUNT
   );

   modport slave (
      input  PRED_VALID, PRED_TAKEN, PRED_PC, PRED_TARGET,
      input  RES_VALID, RES_TAKEN, RES_TARGET,
      output PRED_READY, UPD_ENABLE, UPD_OUTCOME, UPD_INDEX,
      output MISPREDICT, REDIRECT_PC, UNDERFLOW, COUNT
   );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order queue of fetch predictions checked against EX resolution; trains the
// 2-bit predictor and redirects fetch on mispredict. BRU_STATS_EN adds counters.
module branch_resolve_unit #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PC_W  = 32,
   parameter int unsigned IDX_W = 4
) (
   input  logic                 CLOCK,
   input  logic                 RESET_N,
   branch_resolve_unit_if.slave bus
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]          STAT_BRANCHES,
   output logic [31:0]          STAT_MISPRED
`endif
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic            q_taken  [DEPTH];
   logic [PC_W-1:0] q_pc     [DEPTH];
   logic [PC_W-1:0] q_target [DEPTH];

   logic [PTR_W-1:0] wr_ptr, rd_ptr;
   logic [CNT_W-1:0] count;

   logic             upd_enable, upd_outcome, mispredict, underflow;
   logic [IDX_W-1:0] upd_index;
   logic [PC_W-1:0]  redirect_pc;

   logic             pred_ready, push, pop, mismatch;
   logic             head_taken;
   logic [PC_W-1:0]  head_pc, head_target;

   always_comb begin
      pred_ready  = (count < CNT_W'(DEPTH));
      push        = bus.PRED_VALID & pred_ready;
      pop         = bus.RES_VALID & (count != '0);
      head_taken  = q_taken[rd_ptr];
      head_pc     = q_pc[rd_ptr];
      head_target = q_target[rd_ptr];
      mismatch    = pop & ((head_taken != bus.RES_TAKEN) |
                           (bus.RES_TAKEN & head_taken & (head_target != bus.RES_TARGET)));
   end

   // Entry storage needs no reset: occupancy is tracked solely by count/pointers.
   always_ff @(posedge CLOCK) begin
      if (push && !mismatch) begin
         q_taken[wr_ptr]  <= bus.PRED_TAKEN;
         q_pc[wr_ptr]     <= bus.PRED_PC;
         q_target[wr_ptr] <= bus.PRED_TARGET;
      end
   end

   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         upd_enable  <= 1'b0;
         upd_outcome <= 1'b0;
         upd_index   <= '0;
         mispredict  <= 1'b0;
         redirect_pc <= '0;
         underflow   <= 1'b0;
      end else begin
         upd_enable <= pop;
         mispredict <= mismatch;
         if (pop) begin
            upd_outcome <= bus.RES_TAKEN;
            upd_index   <= head_pc[IDX_W+1:2];
         end
         if (bus.RES_VALID && count == '0)
            underflow <= 1'b1;
         // Flush drops every in-flight entry and the wrong-path push of this cycle.
         if (mismatch) begin
            redirect_pc <= bus.RES_TAKEN ? bus.RES_TARGET : head_pc + PC_W'(4);
            rd_ptr      <= wr_ptr;
            count       <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(push) - CNT_W'(pop);
         end
      end
   end

`ifdef BRU_STATS_EN
   always_ff @(posedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         STAT_BRANCHES <= '0;
         STAT_MISPRED  <= '0;
      end else begin
         if (pop && STAT_BRANCHES != '1)
            STAT_BRANCHES <= STAT_BRANCHES + 32'd1;
         if (mismatch && STAT_MISPRED != '1)
            STAT_MISPRED <= STAT_MISPRED + 32'd1;
      end
   end
`endif

   assign bus.PRED_READY  = pred_ready;
   assign bus.UPD_ENABLE  = upd_enable;
   assign bus.UPD_OUTCOME = upd_outcome;
   assign bus.UPD_INDEX   = upd_index;
   assign bus.MISPREDICT  = mispredict;
   assign bus.REDIRECT_PC = redirect_pc;
   assign bus.UNDERFLOW   = underflow;
   assign bus.COUNT       = count;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with a queue-based reference model and
// result scoreboard; checks stats counters when BRU_STATS_EN is defined.
module tb_branch_resolve_unit;
   logic CLOCK = 1'b0;
   logic RESET_N;
   always #5 CLOCK = ~CLOCK;

   branch_resolve_unit_if #(.DEPTH(4), .PC_W(32), .IDX_W(4)) bus ();

`ifdef BRU_STATS_EN
   logic [31:0] stat_branches, stat_mispred;
`endif

   branch_resolve_unit #(.DEPTH(4), .PC_W(32), .IDX_W(4)) dut (
      .CLOCK   (CLOCK),
      .RESET_N (RESET_N),
      .bus     (bus)
`ifdef BRU_STATS_EN
      ,
      .STAT_BRANCHES (stat_branches),
      .STAT_MISPRED  (stat_mispred)
`endif
   );

   typedef struct {
      logic        taken;
      logic [31:0] pc;
      logic [31:0] target;
   } ent_t;

   typedef struct {
      logic        en;
      logic        outcome;
      logic [3:0]  idx;
      logic        mis;
   } exp_t;

   ent_t        mq[$];
   exp_t        sb[$];
   logic [31:0] redir_exp;
   logic        underflow_exp;
   int unsigned exp_branches, exp_mispred;

   int tests  = 0;
   int failed = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.PRED_VALID  = 1'b0;
      bus.PRED_TAKEN  = 1'b0;
      bus.PRED_PC     = '0;
      bus.PRED_TARGET = '0;
      bus.RES_VALID   = 1'b0;
      bus.RES_TAKEN   = 1'b0;
      bus.RES_TARGET  = '0;
   endtask

   task automatic check_reset_state();
      chk("rst_upd_enable",  32'(bus.UPD_ENABLE),  32'd0);
      chk("rst_upd_outcome", 32'(bus.UPD_OUTCOME), 32'd0);
      chk("rst_upd_index",   32'(bus.UPD_INDEX),   32'd0);
      chk("rst_mispredict",  32'(bus.MISPREDICT),  32'd0);
      chk("rst_redirect_pc", bus.REDIRECT_PC,      32'd0);
      chk("rst_underflow",   32'(bus.UNDERFLOW),   32'd0);
      chk("rst_count",       32'(bus.COUNT),       32'd0);
      chk("rst_pred_ready",  32'(bus.PRED_READY),  32'd1);
`ifdef BRU_STATS_EN
      chk("rst_stat_branches", stat_branches, 32'd0);
      chk("rst_stat_mispred",  stat_mispred,  32'd0);
`endif
   endtask

   // Reset asserted mid-cycle so outputs are observed clearing before any clock edge.
   task automatic do_reset();
      @(posedge CLOCK);
      #3 RESET_N = 1'b0;
      #1;
      mq.delete();
      sb.delete();
      redir_exp     = '0;
      underflow_exp = 1'b0;
      exp_branches  = 0;
      exp_mispred   = 0;
      check_reset_state();
      #2 RESET_N = 1'b1;
   endtask

   task automatic step(input logic pv, input logic pt, input logic [31:0] ppc,
                       input logic [31:0] ptgt, input logic rv, input logic rt,
                       input logic [31:0] rtgt);
      ent_t h;
      ent_t n;
      exp_t e;
      logic ready;
      bus.PRED_VALID  = pv;
      bus.PRED_TAKEN  = pt;
      bus.PRED_PC     = ppc;
      bus.PRED_TARGET = ptgt;
      bus.RES_VALID   = rv;
      bus.RES_TAKEN   = rt;
      bus.RES_TARGET  = rtgt;
      ready    = (mq.size() < 4);
      n.taken  = pt;
      n.pc     = ppc;
      n.target = ptgt;
      e.en = 1'b0; e.outcome = 1'b0; e.idx = '0; e.mis = 1'b0;
      if (rv && mq.size() > 0) begin
         h = mq.pop_front();
         e.en      = 1'b1;
         e.outcome = rt;
         e.idx     = h.pc[5:2];
         e.mis     = (h.taken != rt) || (rt && h.taken && (h.target != rtgt));
         exp_branches++;
         if (e.mis) begin
            exp_mispred++;
            redir_exp = rt ? rtgt : h.pc + 32'd4;
            mq.delete();
         end else if (pv && ready) begin
            mq.push_back(n);
         end
      end else begin
         if (rv) underflow_exp = 1'b1;
         if (pv && ready) mq.push_back(n);
      end
      sb.push_back(e);

      @(posedge CLOCK);
      #1;
      idle_inputs();
      e = sb.pop_front();
      chk("upd_enable", 32'(bus.UPD_ENABLE), 32'(e.en));
      if (e.en) begin
         chk("upd_outcome", 32'(bus.UPD_OUTCOME), 32'(e.outcome));
         chk("upd_index",   32'(bus.UPD_INDEX),   32'(e.idx));
      end
      chk("mispredict",  32'(bus.MISPREDICT), 32'(e.mis));
      chk("redirect_pc", bus.REDIRECT_PC,     redir_exp);
      chk("underflow",   32'(bus.UNDERFLOW),  32'(underflow_exp));
      chk("count",       32'(bus.COUNT),      32'(mq.size()));
      chk("pred_ready",  32'(bus.PRED_READY), 32'(mq.size() < 4));
`ifdef BRU_STATS_EN
      chk("stat_branches", stat_branches, 32'(exp_branches));
      chk("stat_mispred",  stat_mispred,  32'(exp_mispred));
`endif
   endtask

   task automatic push(input logic pt, input logic [31:0] pc, input logic [31:0] tgt);
      step(1'b1, pt, pc, tgt, 1'b0, 1'b0, 32'd0);
   endtask

   task automatic resolve(input logic rt, input logic [31:0] tgt);
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, rt, tgt);
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      RESET_N = 1'b0;
      idle_inputs();
      do_reset();

      // Correct taken prediction
      push(1'b1, 32'h100, 32'h200);
      resolve(1'b1, 32'h200);
      idle();

      // Predicted not-taken, actually taken
      push(1'b0, 32'h104, 32'h0);
      resolve(1'b1, 32'h300);
      idle();

      // Predicted taken, actually not-taken
      push(1'b1, 32'h108, 32'h400);
      resolve(1'b0, 32'h0);
      idle();

      // Direction right, target wrong
      push(1'b1, 32'h150, 32'h600);
      resolve(1'b1, 32'h604);
      idle();

      // Fill, overflow push ignored, then drain with a same-cycle push
      push(1'b0, 32'h110, 32'h0);
      push(1'b0, 32'h114, 32'h0);
      push(1'b0, 32'h118, 32'h0);
      push(1'b0, 32'h11C, 32'h0);
      push(1'b0, 32'h120, 32'h0);
      resolve(1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h124, 32'h0, 1'b1, 1'b0, 32'h0);

      // 3 queued; oldest mispredicts while a wrong-path push arrives
      step(1'b1, 1'b0, 32'h140, 32'h0, 1'b1, 1'b1, 32'h900);
      resolve(1'b0, 32'h0);
      idle();
      idle();

      // Counted run: 5 resolves, 2 mispredicts
      do_reset();
      push(1'b0, 32'h200, 32'h0);
      push(1'b1, 32'h204, 32'h700);
      resolve(1'b0, 32'h0);
      resolve(1'b1, 32'h704);
      push(1'b0, 32'h208, 32'h0);
      resolve(1'b1, 32'h800);
      push(1'b1, 32'h20C, 32'hA00);
      push(1'b0, 32'h210, 32'h0);
      resolve(1'b1, 32'hA00);
      resolve(1'b0, 32'h0);
`ifdef BRU_STATS_EN
      chk("stat_branches_total", stat_branches, 32'd5);
      chk("stat_mispred_total",  stat_mispred,  32'd2);
`endif

      // Reset with entries in flight, then a resolve finds nothing to train
      push(1'b1, 32'h300, 32'hB00);
      push(1'b0, 32'h304, 32'h0);
      do_reset();
      resolve(1'b1, 32'hB00);
      idle();

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Resolution-side partner of the 2-bit saturating-counter predictor.
- Keeps an in-order queue of predictions issued at fetch. When each branch resolves in EX, it compares the actual outcome with the queued prediction.
- Drives the predictor's training inputs (ENABLE/OUTCOME plus table index). On a wrong guess it raises a one-cycle mispredict/redirect to fetch and flushes the in-flight queue.

Parameters:
- DEPTH, 4, number of in-flight predicted branches held; power of two, at least 2.
- PC_W, 32, program-counter width.
- IDX_W, 4, predictor-table index width; index = PC[IDX_W+1:2].

Ports:
- CLOCK  input  1  single clock; all state updates on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- PRED_VALID  input  1  fetch pushes a predicted branch this cycle.
- PRED_READY  output  1  queue can accept a push; equals (count < DEPTH).
- PRED_TAKEN  input  1  predicted direction.
- PRED_PC  input  PC_W  branch PC.
- PRED_TARGET  input  PC_W  predicted target; used only when PRED_TAKEN=1.
- RES_VALID  input  1  oldest in-flight branch resolves this cycle.
- RES_TAKEN  input  1  actual direction.
- RES_TARGET  input  PC_W  actual target.
- UPD_ENABLE  output  1  predictor train strobe; one pulse per resolved branch.
- UPD_OUTCOME  output  1  actual direction to train with.
- UPD_INDEX  output  IDX_W  predictor entry to train.
- MISPREDICT  output  1  one-cycle flush/redirect pulse.
- REDIRECT_PC  output  PC_W  correct next PC; valid while MISPREDICT=1.
- UNDERFLOW  output  1  sticky error: resolve arrived with an empty queue.
- COUNT  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (async, RESET_N=0):
  - Queue emptied; read and write pointers = 0; COUNT=0.
  - UPD_ENABLE=0, UPD_OUTCOME=0, UPD_INDEX=0, MISPREDICT=0, REDIRECT_PC=0, UNDERFLOW=0.
  - PRED_READY=1 immediately after reset.
- Queue:
  - Circular buffer; each entry holds {taken, pc, target}.
  - A push occurs when PRED_VALID & PRED_READY. Pushes while full are ignored, and the queue is unchanged.
  - Pointers wrap modulo DEPTH.
- Resolution:
  - A pop occurs when RES_VALID and COUNT>0; it is compared against the head entry.
  - mismatch = (head.taken != RES_TAKEN) | (RES_TAKEN & head.taken & head.target != RES_TARGET).
  - All outputs are registered: results appear the cycle after RES_VALID (1-cycle latency).
  - On that cycle: UPD_ENABLE=1, UPD_OUTCOME=RES_TAKEN, UPD_INDEX=head.pc[IDX_W+1:2].
- Mispredict:
  - MISPREDICT=1 for exactly one cycle.
  - REDIRECT_PC = RES_TARGET if RES_TAKEN, else head.pc+4, modulo 2^PC_W.
  - The whole queue is flushed at the same edge; COUNT becomes 0.
  - A push in the same cycle as a mispredicting resolve is discarded, because it is wrong-path.
- Correct prediction: MISPREDICT=0 and REDIRECT_PC holds its previous value.
- Simultaneous push and correct resolve: both take effect; COUNT unchanged. Not possible when full, since PRED_READY=0.
- Resolve on empty queue:
  - No update and no mispredict; UPD_ENABLE=0.
  - UNDERFLOW sets and stays 1 until reset.
- Idle cycles (no RES_VALID): UPD_ENABLE=0 and MISPREDICT=0.
- Reset mid-operation: in-flight entries are lost and all outputs return to reset values asynchronously. No update is emitted for branches lost this way.

Optional Feature:
- Macro: BRU_STATS_EN.
- When defined:
  - Adds outputs STAT_BRANCHES (32 bits) and STAT_MISPRED (32 bits).
  - Each increments on a valid resolve / a mispredicting resolve respectively, and saturates at 32'hFFFFFFFF.
  - Both cleared by RESET_N; updated in the same cycle UPD_ENABLE/MISPREDICT rise.
- When undefined: those ports and counters do not exist; the rest of the behaviour is identical.

Test Plan:
- Reset, then push {taken=1, pc=0x100, target=0x200}, then resolve {taken=1, target=0x200} -> next cycle UPD_ENABLE=1, UPD_OUTCOME=1, UPD_INDEX=0x0, MISPREDICT=0; COUNT 1->0.
- Push {taken=0, pc=0x104}, resolve taken=1, target=0x300 -> MISPREDICT=1 for one cycle, REDIRECT_PC=0x300, UPD_OUTCOME=1, UPD_INDEX=0x1.
- Push {taken=1, pc=0x108, target=0x400}, resolve taken=0 -> MISPREDICT=1, REDIRECT_PC=0x10C, UPD_OUTCOME=0.
- Push 4 branches -> PRED_READY=0, and a 5th push is ignored. Then 2 correct resolves plus 1 push in the same cycle as the second resolve -> COUNT=3, in-order UPD_INDEX values.
- 3 queued; the oldest mispredicts while PRED_VALID=1 -> COUNT=0 the next cycle and the same-cycle push is dropped. A subsequent resolve -> UNDERFLOW=1 and stays 1; no UPD_ENABLE.
- With BRU_STATS_EN: 5 resolves, of which 2 mispredict -> STAT_BRANCHES=5, STAT_MISPRED=2. RESET_N pulsed low mid-queue -> all counters and outputs are 0 asynchronously.
